// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage register.
//   - pipe_state_t : occupancy state of a stage (EMPTY / ONE / TWO)
//   - *_W          : payload widths of the standard inter-stage structs
//   - *_t          : packed stage structs that callers pack into the payload
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry of the elastic stage (payload + valid bit).
// Ports:
//   CLK, nRST  clock (rising edge) and synchronous active-low reset
//   i_load     capture i_data and mark the entry valid
//   i_clear    invalidate the entry (wins over i_load)
//   i_zero     together with i_clear, also zero the stored payload
//   i_data     payload to capture
//   o_valid    entry holds a beat
//   o_data     stored payload
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_zero,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            // NOTE: the payload is reset as well, so out_data reads 0 after
            // reset instead of whatever the flops powered up with.
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            if (i_zero) r_data <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: generic pipeline stage register with valid/ready
// handshake, synchronous flush and an optional skid entry.
// Parameters:
//   PAYLOAD_W   payload width in bits
//   SKID        1 = main + skid entries, in_ready from a register
//               0 = single entry, in_ready combinational
//   FLUSH_ZERO  1 = flush also zeroes the stored payloads
// Ports:
//   CLK, nRST            clock and synchronous active-low reset
//   flush                drop every held beat (and any beat presented now)
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload
//   occupancy            entries held (0..2)
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W  = 128,
    parameter bit          SKID       = 1'b1,
    parameter bit          FLUSH_ZERO = 1'b0
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    pipe_state_t          r_state;
    pipe_state_t          w_state_nxt;
    logic                 w_accept;
    logic                 w_consume;
    logic                 w_zero;
    logic                 w_main_load;
    logic                 w_main_clear;
    logic                 w_main_valid;
    logic [PAYLOAD_W-1:0] w_main_din;
    logic [PAYLOAD_W-1:0] w_main_data;
    logic                 w_skid_valid;
    logic [PAYLOAD_W-1:0] w_skid_data;

    // A beat presented together with flush is dropped, so it never counts
    // as accepted even when in_ready is high.
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_consume = w_main_valid & out_ready;
    assign w_zero    = flush & FLUSH_ZERO;

    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= PS_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        if (flush) begin
            w_state_nxt  = PS_EMPTY;
            w_main_clear = 1'b1;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = PS_ONE;
                        w_main_load = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        // Only reachable with SKID=1; the skid slot captures.
                        w_state_nxt = PS_TWO;
                    end else if (w_consume) begin
                        w_state_nxt  = PS_EMPTY;
                        w_main_clear = 1'b1;
                    end
                end
                PS_TWO: begin
                    if (w_consume) begin
                        w_state_nxt = PS_ONE;
                        w_main_load = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = PS_EMPTY;
                    w_main_clear = 1'b1;
                end
            endcase
        end
    end

    // In TWO the main entry refills from the skid entry, otherwise from input.
    assign w_main_din = (r_state == PS_TWO) ? w_skid_data : in_data;

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_zero  (w_zero),
        .i_data  (w_main_din),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    generate
        if (SKID) begin : g_skid
            logic w_skid_load;
            logic w_skid_clear;

            assign w_skid_load  = (r_state == PS_ONE) & w_accept & ~w_consume;
            assign w_skid_clear = flush | ((r_state == PS_TWO) & w_consume);

            pipe_slot #(.W(PAYLOAD_W)) u_skid (
                .CLK     (CLK),
                .nRST    (nRST),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_zero  (w_zero),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data)
            );

            // Straight from a flop: no ready path from out_ready to in_ready.
            assign in_ready = ~w_skid_valid;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_data  = '0;
            assign in_ready     = ~w_main_valid | out_ready;
        end
    endgenerate

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic. Three instances share one set of
// inputs: SKID=1/FLUSH_ZERO=0, SKID=1/FLUSH_ZERO=1 and SKID=0. Each scenario
// checks the instance(s) it targets. Inputs change and outputs are sampled
// 1 time unit after the rising clock edge.
module tb_pipe_stage_elastic;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_occ;
    logic         z_in_ready, z_out_valid;
    logic [W-1:0] z_out_data;
    logic [1:0]   z_occ;
    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_occ;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipe_stage_elastic #(.PAYLOAD_W(W), .SKID(1'b1), .FLUSH_ZERO(1'b0)) u_a (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_elastic #(.PAYLOAD_W(W), .SKID(1'b1), .FLUSH_ZERO(1'b1)) u_z (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
        .occupancy(z_occ)
    );

    pipe_stage_elastic #(.PAYLOAD_W(W), .SKID(1'b0), .FLUSH_ZERO(1'b0)) u_s (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Idle inputs with the consumer ready until every instance is empty.
    task automatic drain();
        drive(1'b0, 'x, 1'b1, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        tick();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_out_data !== 8'h00) begin n_err++; $display("FAIL reset_a_data: got %h want 00", a_out_data); end
        n_vec++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL reset_a_occ: got %0d want 0", a_occ); end
        n_vec++; if (z_out_data !== 8'h00) begin n_err++; $display("FAIL reset_z_data: got %h want 00", z_out_data); end
        n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_s_valid: got %b want 0", s_out_valid); end
        n_vec++; if (s_out_data !== 8'h00) begin n_err++; $display("FAIL reset_s_data: got %h want 00", s_out_data); end
        nRST = 1'b1;
        drive(1'b0, 'x, 1'b0, 1'b0);
        tick();
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_ready: got %b want 1", a_in_ready); end
        n_vec++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_z_ready: got %b want 1", z_in_ready); end
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_in_ready); end
        n_vec++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL reset_a_occ_rel: got %0d want 0", a_occ); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            tick();
            n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== W'(i)) begin n_err++; $display("FAIL stream_a_out[%0d]: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, W'(i)); end
            n_vec++; if (a_in_ready !== 1'b1 || a_occ !== 2'd1) begin n_err++; $display("FAIL stream_a_ctl[%0d]: got rdy=%b occ=%0d want rdy=1 occ=1", i, a_in_ready, a_occ); end
            n_vec++; if (s_out_data !== W'(i)) begin n_err++; $display("FAIL stream_s_out[%0d]: got %h want %h", i, s_out_data, W'(i)); end
        end
        drive(1'b0, 'x, 1'b1, 1'b0);
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL stream_a_end: got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        tick();
        n_vec++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 8'h10) begin n_err++; $display("FAIL bp_first: got occ=%0d rdy=%b d=%h want occ=1 rdy=1 d=10", a_occ, a_in_ready, a_out_data); end
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        n_vec++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got occ=%0d rdy=%b want occ=2 rdy=0", a_occ, a_in_ready); end
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        tick();
        n_vec++; if (a_occ !== 2'd2 || a_out_data !== 8'h10 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold: got occ=%0d d=%h rdy=%b want occ=2 d=10 rdy=0", a_occ, a_out_data, a_in_ready); end
        // Consumer takes 0x10 at the next edge; 0x12 is still pending upstream.
        drive(1'b1, 8'h12, 1'b1, 1'b0);
        tick();
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h11 || a_occ !== 2'd1) begin n_err++; $display("FAIL bp_drain1: got v=%b d=%h occ=%0d want v=1 d=11 occ=1", a_out_valid, a_out_data, a_occ); end
        tick();
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h12 || a_occ !== 2'd1) begin n_err++; $display("FAIL bp_drain2: got v=%b d=%h occ=%0d want v=1 d=12 occ=1", a_out_valid, a_out_data, a_occ); end
        drive(1'b0, 'x, 1'b1, 1'b0);
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ); end
        drain();
    endtask

    task automatic test_flush_full();
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        tick();
        n_vec++; if (a_occ !== 2'd2 || z_occ !== 2'd2) begin n_err++; $display("FAIL flush_pre: got a_occ=%0d z_occ=%0d want 2 2", a_occ, z_occ); end
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_a: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", a_out_valid, a_occ, a_in_ready); end
        n_vec++; if (a_out_data !== 8'h20) begin n_err++; $display("FAIL flush_a_hold: got %h want 20", a_out_data); end
        n_vec++; if (z_out_valid !== 1'b0 || z_out_data !== 8'h00 || z_occ !== 2'd0) begin n_err++; $display("FAIL flush_z: got v=%b d=%h occ=%0d want v=0 d=00 occ=0", z_out_valid, z_out_data, z_occ); end
        drive(1'b0, 'x, 1'b1, 1'b0);
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || z_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop22: got a_v=%b z_v=%b want 0 0", a_out_valid, z_out_valid); end
        drain();
    endtask

    task automatic test_flush_consume();
        drive(1'b1, 8'h30, 1'b0, 1'b0);
        tick();
        drive(1'b0, 'x, 1'b1, 1'b1);
        #1;
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h30) begin n_err++; $display("FAIL fc_offer: got v=%b d=%h want v=1 d=30", a_out_valid, a_out_data); end
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL fc_empty: got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ); end
        drive(1'b0, 'x, 1'b1, 1'b0);
        tick();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL fc_nodup: got v=%b want 0", a_out_valid); end
        drain();
    endtask

    task automatic test_skid0_stall();
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        tick();
        n_vec++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h40 || s_occ !== 2'd1) begin n_err++; $display("FAIL s0_load: got v=%b d=%h occ=%0d want v=1 d=40 occ=1", s_out_valid, s_out_data, s_occ); end
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        #1;
        n_vec++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_stall_ready: got %b want 0", s_in_ready); end
        tick();
        n_vec++; if (s_out_data !== 8'h40 || s_out_valid !== 1'b1) begin n_err++; $display("FAIL s0_stall_hold: got v=%b d=%h want v=1 d=40", s_out_valid, s_out_data); end
        drive(1'b1, 8'h41, 1'b1, 1'b0);
        #1;
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_release_ready: got %b want 1", s_in_ready); end
        tick();
        n_vec++; if (s_out_data !== 8'h41 || s_out_valid !== 1'b1) begin n_err++; $display("FAIL s0_next: got v=%b d=%h want v=1 d=41", s_out_valid, s_out_data); end
        drive(1'b0, 'x, 1'b1, 1'b0);
        tick();
        n_vec++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin n_err++; $display("FAIL s0_empty: got v=%b occ=%0d want v=0 occ=0", s_out_valid, s_occ); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h50, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h51, 1'b0, 1'b0);
        tick();
        nRST = 1'b0;
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 8'h00) begin n_err++; $display("FAIL rst_mid: got v=%b occ=%0d d=%h want v=0 occ=0 d=00", a_out_valid, a_occ, a_out_data); end
        nRST = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_flush_consume();
        test_skid0_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field inter-stage latch. It is a generic pipeline stage register with a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer.
- Placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- The payload is an opaque packed vector; callers pack their stage struct into it.
- Replaces the single "enable" hold input with backpressure, so a stall propagates without a combinational ready chain when SKID=1.

Parameters:
- PAYLOAD_W, 128: width of the in_data/out_data payload in bits (min 1).
- SKID, 1: 1 = two entries (main + skid), in_ready registered; 0 = single entry, in_ready combinational.
- FLUSH_ZERO, 0: 1 = flush also zeroes stored payload; 0 = payload left unchanged, only valid bits cleared.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- flush  in  1  synchronous invalidate of all held entries
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  PAYLOAD_W  upstream payload
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  downstream consumes out_data this cycle
- out_data  out  PAYLOAD_W  registered payload to downstream
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset: sampled only at the CLK rising edge while nRST=0. It clears out_valid, skid valid, out_data and skid data to 0, and sets occupancy to 0. in_ready is 1 from the first edge after reset is released. A reset asserted mid-transfer drops all held beats.
- Terms: accept = in_valid & in_ready; consume = out_valid & out_ready. Input-to-output latency is 1 cycle. Peak throughput is 1 beat/cycle. Order is preserved and no beat is duplicated.
- SKID=0: in_ready = !out_valid | out_ready (combinational).
  - On accept: out_data <= in_data and out_valid <= 1.
  - On consume without accept: out_valid <= 0.
  - out_data holds whenever no accept occurs.
- SKID=1: in_ready = !skid_valid, driven from a register. State = {EMPTY, ONE, TWO}.
  - EMPTY: accept -> ONE, main <= in.
  - ONE, accept & consume -> ONE, main <= in.
  - ONE, accept & !consume -> TWO, skid <= in.
  - ONE, !accept & consume -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: consume -> ONE, main <= skid. No accept is possible because in_ready=0.
  - occupancy encodes the state: EMPTY=0, ONE=1, TWO=2.
- out_valid=1 in states ONE and TWO. out_data always equals the main entry.
- Flush (highest priority after reset):
  - Next state is EMPTY/invalid and occupancy is 0.
  - A beat presented with flush is dropped, even if in_ready=1.
  - A simultaneous consume still counts downstream; the beat is taken by the consumer as-is.
  - With FLUSH_ZERO=1 the payloads become 0; with FLUSH_ZERO=0 they hold.
- Holding: out_valid & !out_ready keeps out_data stable (never changes while waiting). This is a protocol guarantee.
- in_valid=0: in_data is ignored, X-tolerant.
- Width: payloads are copied bit-exact, with no arithmetic performed.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {PS_EMPTY=0, PS_ONE=1, PS_TWO=2} pipe_state_t.
  - Localparam helpers for standard stage payload widths (e.g. ID_EX_W) and the packed stage structs.
- One sub-module, pipe_slot: a PAYLOAD_W register with load, clear and valid bit. It is instantiated once for main and, under generate SKID=1, once for skid.
- Control FSM lives in the top module.

Test Plan:
- Reset: nRST=0 for 2 cycles while in_valid=1 and in_data=0xAA -> out_valid=0, out_data=0, occupancy=0. One cycle after release, in_ready=1.
- Streaming: SKID=1, out_ready=1, send 0x1..0x8 back-to-back -> out_data shows 0x1..0x8 on consecutive cycles, each 1 cycle after input. in_ready stays 1 and occupancy stays 1.
- Backpressure: SKID=1, send 0x10,0x11,0x12 with out_ready=0 -> occupancy goes 1 then 2. in_ready=0 after 0x11, and 0x12 is held upstream. Raising out_ready then gives the sequence 0x10,0x11,0x12 with no loss.
- Flush at full: SKID=1 in TWO (0x20,0x21), assert flush with in_valid=1 and in_data=0x22 -> next cycle out_valid=0 and occupancy=0. 0x22 never appears at the output. With FLUSH_ZERO=1, out_data=0.
- Flush with consume: SKID=1 in ONE (0x30), flush=1 and out_ready=1 in the same cycle -> 0x30 is consumed once, then EMPTY.
- SKID=0 passthrough stall: out_ready=0 while holding 0x40 -> in_ready=0 and out_data stays 0x40. When out_ready=1 with in_valid=1 and in_data=0x41, the next out_data=0x41.
